reset_sequencer: RTL and testbench

- Parametrised successor to the single-output boot reset generator used by the processorci top level.
- Produces NUM_DOMAINS staggered active-high resets, e.g. controller, core and peripherals. Each domain is released STAGE_GAP cycles after the previous one.
- Also produces a free-running divided clock-enable and accepts a soft-reset request from the Controller to re-run the sequence.
- Sits between the board clock and every reset consumer in processorci_top.

---
 rtl/reset_sequencer.sv | 177 +++++++++++++++++
 tb/tb_reset_sequencer.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/reset_sequencer.sv
// Staggered multi-domain reset generator with free-running clock-enable divider.
// Optional watchdog restart is compiled in with `define RESET_SEQ_WATCHDOG_EN.
module reset_sequencer #(
  parameter int CYCLES      = 20,
  parameter int NUM_DOMAINS = 2,
  parameter int STAGE_GAP   = 4,
  parameter int CLK_DIV     = 2,
  parameter int WDT_CYCLES  = 1000000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   soft_reset_req,
  input  logic                   wdt_kick,
  output logic                   clk_en_o,
  output logic [NUM_DOMAINS-1:0] reset_o,
  output logic                   busy,
  output logic                   done_pulse,
  output logic                   wdt_fired
);

  localparam int CNT_MAX = (CYCLES > STAGE_GAP) ? CYCLES : STAGE_GAP;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int DOM_W   = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    STAGGER = 2'd1,
    RUN     = 2'd2
  } state_t;

  state_t                 state_reg = HOLD;
  state_t                 state_next;
  logic [CNT_W-1:0]       count_reg = '0;
  logic [CNT_W-1:0]       count_next;
  logic [DOM_W-1:0]       dom_reg   = '0;
  logic [DOM_W-1:0]       dom_next;
  logic [NUM_DOMAINS-1:0] rst_reg   = '1;
  logic [NUM_DOMAINS-1:0] rst_next;
  logic                   busy_reg  = 1'b1;
  logic                   busy_next;
  logic                   done_reg  = 1'b0;
  logic                   done_next;
  logic [DIV_W-1:0]       div_reg   = '0;
  logic                   en_reg    = 1'b0;
  logic                   wdt_expire;
  logic                   restart;

  assign restart = soft_reset_req | wdt_expire;

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    dom_next   = dom_reg;
    rst_next   = rst_reg;
    busy_next  = busy_reg;
    done_next  = 1'b0;
    case (state_reg)
      HOLD: begin
        count_next = count_reg + CNT_W'(1);
        if (count_reg == CNT_W'(CYCLES - 1)) begin
          rst_next[0] = 1'b0;
          count_next  = '0;
          dom_next    = DOM_W'(1);
          if (NUM_DOMAINS == 1) begin
            state_next = RUN;
            busy_next  = 1'b0;
            done_next  = 1'b1;
          end else begin
            state_next = STAGGER;
          end
        end
      end
      STAGGER: begin
        count_next = count_reg + CNT_W'(1);
        if (count_reg == CNT_W'(STAGE_GAP - 1)) begin
          // dom_reg always names the lowest still-held domain, so releases stay ordered
          count_next        = '0;
          rst_next[dom_reg] = 1'b0;
          dom_next          = dom_reg + DOM_W'(1);
          if (dom_reg == DOM_W'(NUM_DOMAINS - 1)) begin
            state_next = RUN;
            busy_next  = 1'b0;
            done_next  = 1'b1;
          end
        end
      end
      RUN: begin
        rst_next  = '0;
        busy_next = 1'b0;
      end
      default: begin
        state_next = HOLD;
        count_next = '0;
        dom_next   = '0;
        rst_next   = '1;
        busy_next  = 1'b1;
      end
    endcase
    // A restart overrides whatever the sequence was about to do, including a final release
    if (restart) begin
      state_next = HOLD;
      count_next = '0;
      dom_next   = '0;
      rst_next   = '1;
      busy_next  = 1'b1;
      done_next  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= HOLD;
      count_reg <= '0;
      dom_reg   <= '0;
      rst_reg   <= '1;
      busy_reg  <= 1'b1;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      dom_reg   <= dom_next;
      rst_reg   <= rst_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
    end
  end

  // Divider phase is tied to hard reset only, so soft restarts never disturb it
  always_ff @(posedge clk) begin
    if (reset) begin
      div_reg <= '0;
      en_reg  <= 1'b0;
    end else begin
      en_reg  <= (div_reg == DIV_W'(CLK_DIV - 1));
      div_reg <= (div_reg == DIV_W'(CLK_DIV - 1)) ? '0 : div_reg + DIV_W'(1);
    end
  end

`ifdef RESET_SEQ_WATCHDOG_EN
  localparam int WDT_W = $clog2(WDT_CYCLES + 1);

  logic [WDT_W-1:0] wdt_cnt_reg   = '0;
  logic             wdt_fired_reg = 1'b0;

  // A kick on the expiry cycle keeps the system alive
  assign wdt_expire = (state_reg == RUN) && !wdt_kick &&
                      (wdt_cnt_reg == WDT_W'(WDT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      wdt_cnt_reg   <= '0;
      wdt_fired_reg <= 1'b0;
    end else begin
      if (state_reg != RUN || wdt_kick || wdt_expire || soft_reset_req)
        wdt_cnt_reg <= '0;
      else
        wdt_cnt_reg <= wdt_cnt_reg + WDT_W'(1);
      if (wdt_expire)
        wdt_fired_reg <= 1'b1;
    end
  end

  assign wdt_fired = wdt_fired_reg;
`else
  logic unused_kick;
  assign unused_kick = wdt_kick;
  assign wdt_expire  = 1'b0;
  assign wdt_fired   = 1'b0;
`endif

  assign reset_o    = rst_reg;
  assign busy       = busy_reg;
  assign done_pulse = done_reg;
  assign clk_en_o   = en_reg;

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer: expected outputs are derived from the
// number of edges since the last restart and queued per driven cycle.
module tb_reset_sequencer;

  localparam int CYC   = 20;
  localparam int ND    = 3;
  localparam int GAP   = 4;
  localparam int DIV   = 2;
  localparam int WDT   = 100;
  localparam int FINAL = CYC + (ND - 1) * GAP;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          soft_reset_req = 1'b0;
  logic          wdt_kick = 1'b1;
  logic          clk_en_o, busy, done_pulse, wdt_fired;
  logic [ND-1:0] reset_o;
  logic          clk_en_o1, busy1, done_pulse1, wdt_fired1;
  logic [0:0]    reset_o1;

  reset_sequencer #(
    .CYCLES(CYC), .NUM_DOMAINS(ND), .STAGE_GAP(GAP), .CLK_DIV(DIV), .WDT_CYCLES(WDT)
  ) dut (
    .clk(clk), .reset(reset), .soft_reset_req(soft_reset_req), .wdt_kick(wdt_kick),
    .clk_en_o(clk_en_o), .reset_o(reset_o), .busy(busy), .done_pulse(done_pulse),
    .wdt_fired(wdt_fired)
  );

  // Single-domain, undivided variant sharing the same reset/request stimulus
  reset_sequencer #(
    .CYCLES(CYC), .NUM_DOMAINS(1), .STAGE_GAP(GAP), .CLK_DIV(1), .WDT_CYCLES(WDT)
  ) dut1 (
    .clk(clk), .reset(reset), .soft_reset_req(soft_reset_req), .wdt_kick(1'b1),
    .clk_en_o(clk_en_o1), .reset_o(reset_o1), .busy(busy1), .done_pulse(done_pulse1),
    .wdt_fired(wdt_fired1)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ND-1:0] ro;
    logic busy, done, en, wf;
    logic ro1, busy1, done1, en1;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  int m_since  = 0;
  int m_since1 = 0;
  int m_div    = 0;
  int m_idle   = 0;
  bit m_en = 1'b0, m_en1 = 1'b0, m_wf = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s at t=%0t: got %0h expected %0h", tag, $time, got, want);
    end
  endtask

  // Advance the reference by one clock edge with the given inputs sampled
  task automatic model_edge(input bit r, input bit s, input bit k);
    bit rs;
    rs = s;
    if (r) begin
      m_since = 0; m_since1 = 0; m_div = 0; m_idle = 0;
      m_en = 1'b0; m_en1 = 1'b0; m_wf = 1'b0;
    end else begin
      m_en  = (m_div == DIV - 1);
      m_div = (m_div + 1) % DIV;
      m_en1 = 1'b1;
`ifdef RESET_SEQ_WATCHDOG_EN
      if (m_since >= FINAL) begin
        if (k) m_idle = 0;
        else if (m_idle == WDT - 1) begin rs = 1'b1; m_wf = 1'b1; end
        else m_idle++;
      end
`endif
      if (rs) begin m_since = 0; m_idle = 0; end
      else m_since++;
      m_since1 = s ? 0 : m_since1 + 1;
    end
  endtask

  task automatic step(input bit r, input bit s, input bit k);
    exp_t e;
    reset = r; soft_reset_req = s; wdt_kick = k;
    model_edge(r, s, k);
    for (int i = 0; i < ND; i++) e.ro[i] = (m_since < CYC + i * GAP);
    e.busy  = (m_since < FINAL);
    e.done  = (m_since == FINAL);
    e.en    = m_en;
    e.wf    = m_wf;
    e.ro1   = (m_since1 < CYC);
    e.busy1 = (m_since1 < CYC);
    e.done1 = (m_since1 == CYC);
    e.en1   = m_en1;
    sb_q.push_back(e);
    @(negedge clk);
    #1;
  endtask

  task automatic run_to(input int target, input bit k);
    for (int n = 0; n < 2000 && m_since != target; n++) step(1'b0, 1'b0, k);
  endtask

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      $display("t=%0t reset_o=%b busy=%b done=%b clk_en=%b wdt=%b | d1 %b%b%b%b",
               $time, reset_o, busy, done_pulse, clk_en_o, wdt_fired,
               reset_o1, busy1, done_pulse1, clk_en_o1);
      check("reset_o",    32'(reset_o),     32'(e.ro));
      check("busy",       32'(busy),        32'(e.busy));
      check("done_pulse", 32'(done_pulse),  32'(e.done));
      check("clk_en_o",   32'(clk_en_o),    32'(e.en));
      check("wdt_fired",  32'(wdt_fired),   32'(e.wf));
      check("d1_reset_o", 32'(reset_o1),    32'(e.ro1));
      check("d1_busy",    32'(busy1),       32'(e.busy1));
      check("d1_done",    32'(done_pulse1), 32'(e.done1));
      check("d1_clk_en",  32'(clk_en_o1),   32'(e.en1));
      check("d1_wdt",     32'(wdt_fired1),  32'd0);
    end
  end

  initial begin
    // Reset held for three clocks, then the full staggered release
    repeat (3) step(1'b1, 1'b0, 1'b1);
    run_to(40, 1'b1);

    // Soft request once in RUN
    run_to(49, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    run_to(40, 1'b1);

    // Request mid-stagger (reset_o=100), then one coincident with the final release
    step(1'b0, 1'b1, 1'b1);
    run_to(24, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    run_to(27, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    run_to(40, 1'b1);

    // Request held high keeps the sequence parked at the start
    repeat (5) step(1'b0, 1'b1, 1'b1);
    run_to(35, 1'b1);

    // Hard reset together with soft request mid-stagger
    step(1'b0, 1'b1, 1'b1);
    run_to(21, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    run_to(40, 1'b1);

    // Watchdog left unserviced, then serviced every 50 clocks, then a soft restart
    repeat (250) step(1'b0, 1'b0, 1'b0);
    for (int n = 0; n < 300; n++) step(1'b0, 1'b0, (n % 50) == 0);
    step(1'b0, 1'b1, 1'b0);
    run_to(40, 1'b0);

    check("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got t=%0t expected < 200000", $time);
    $fatal(1);
  end

endmodule
